// File: rtl/pio_edge_capture_slave.sv
// Avalon-MM PIO responder: synchronised, debounced inputs with edge capture,
// masked level interrupt and an output register.
module pio_edge_capture_slave #(
  parameter int IN_WIDTH        = 4,
  parameter int OUT_WIDTH       = 7,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int CMAX_I =
    (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CMAX = CW'(CMAX_I);

  logic [IN_WIDTH-1:0]  s1, s2, d, d_nxt;
  logic [IN_WIDTH-1:0]  mask, cap, cap_nxt;
  logic [IN_WIDTH-1:0]  rise, fall, edge_hit, w1c;
  logic [OUT_WIDTH-1:0] out_q;
  logic [CW-1:0]        cnt_q [IN_WIDTH];
  logic [CW-1:0]        cnt_n [IN_WIDTH];
  logic [31:0]          rd_mux;
  logic                 a_data, a_mask, a_cap, a_out;
  logic                 unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign a_data = (avs_address == 2'd0);
  assign a_mask = (avs_address == 2'd1);
  assign a_cap  = (avs_address == 2'd2);
  assign a_out  = (avs_address == 2'd3);

  // Two-flop synchroniser on the raw asynchronous inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Per-bit debounce: a change must sit at s2 for N cycles to be accepted.
  always_comb begin
    d_nxt = d;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_n[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        d_nxt[i] = s2[i];
      end else if (s2[i] == d[i]) begin
        cnt_n[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        d_nxt[i] = s2[i];
        cnt_n[i] = '0;
      end else begin
        cnt_n[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      d <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      d <= d_nxt;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_n[i];
    end
  end

  // Edge selection; a new edge overrides a same-cycle clear.
  always_comb begin
    rise = d_nxt & ~d;
    fall = ~d_nxt & d;
    if (EDGE_MODE == 0)
      edge_hit = rise;
    else if (EDGE_MODE == 1)
      edge_hit = fall;
    else
      edge_hit = rise | fall;
    w1c = '0;
    if (avs_write && a_cap)
      w1c = avs_writedata[IN_WIDTH-1:0];
    cap_nxt = (cap & ~w1c) | edge_hit;
  end

  // Capture, mask and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cap   <= '0;
      mask  <= '0;
      out_q <= '0;
    end else begin
      cap <= cap_nxt;
      if (avs_write && a_mask)
        mask <= avs_writedata[IN_WIDTH-1:0];
      if (avs_write && a_out)
        out_q <= avs_writedata[OUT_WIDTH-1:0];
    end
  end

  // Read mux sees pre-write register values.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      a_data: rd_mux = 32'(d);
      a_mask: rd_mux = 32'(mask);
      a_cap:  rd_mux = 32'(cap);
      a_out:  rd_mux = 32'(out_q);
      default: rd_mux = '0;
    endcase
  end

  // Read data is registered on the read strobe and held until the next read.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_mux;
  end

  assign irq      = |(cap & mask);
  assign out_port = out_q;

endmodule

// File: tb/tb_pio_edge_capture_slave.sv
// Bench for pio_edge_capture_slave: a bypass instance (A) and a
// 4-cycle debounced instance (B) share one bus and clock.
module tb_pio_edge_capture_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [3:0]  in_a, in_b;
  logic [6:0]  out_a, out_b;

  always #5 clk = ~clk;

  pio_edge_capture_slave #(
    .IN_WIDTH(4), .OUT_WIDTH(7),
    .DEBOUNCE_CYCLES(0), .EDGE_MODE(1)
  ) u_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(rdata_a), .irq(irq_a),
    .in_port(in_a), .out_port(out_a)
  );

  pio_edge_capture_slave #(
    .IN_WIDTH(4), .OUT_WIDTH(7),
    .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)
  ) u_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(rdata_b), .irq(irq_b),
    .in_port(in_b), .out_port(out_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r,
                     input logic [1:0] a, input logic [31:0] wd,
                     input logic sel, input logic [31:0] exp,
                     input string nm);
    sb_t s;
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = wd;
    if (r) sbq.push_back('{sel, exp});
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    if (r) begin
      if (sbq.size() == 0) begin
        chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        s = sbq.pop_front();
        chk(nm, s.sel ? rdata_b : rdata_a, s.exp);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b0, 32'h7F};
    vt[2] = '{1'b1, 1'b1, 2'd3, 32'h15,        1'b0, 32'h7F};
    vt[3] = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b0, 32'h15};
    vt[4] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[5] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b0, 32'hF};
    vt[6] = '{1'b1, 1'b1, 2'd0, 32'h0,         1'b0, 32'hF};
    vt[7] = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b0, 32'h0};
    vt[8] = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'hF};
    vt[9] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'hF};

    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = '0;
    in_a = 4'hF; in_b = 4'hF;

    repeat (3) @(negedge clk);
    chk("rst_out_a", 32'(out_a), 32'h0);
    chk("rst_out_b", 32'(out_b), 32'h0);
    chk("rst_irq_a", 32'(irq_a), 32'h0);
    chk("rst_irq_b", 32'(irq_b), 32'h0);
    chk("rst_rd_a", rdata_a, 32'h0);
    chk("rst_rd_b", rdata_b, 32'h0);

    rst_n = 1'b1;
    cycles(4);
    bus(1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'hF, "data_a_boot");

    for (int i = 0; i < 10; i++)
      bus(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata,
          vt[i].sel, vt[i].exp, $sformatf("vec%0d", i));
    chk("out_a_15", 32'(out_a), 32'h15);
    chk("out_b_15", 32'(out_b), 32'h15);

    bus(1'b1, 1'b0, 2'd1, 32'h1, 1'b0, 32'h0, "mask1");
    @(negedge clk);
    in_a = 4'hE;
    @(posedge clk); #1; chk("lat_k",  32'(irq_a), 32'h0);
    @(posedge clk); #1; chk("lat_k1", 32'(irq_a), 32'h0);
    @(posedge clk); #1; chk("lat_k2", 32'(irq_a), 32'h1);
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h1, "cap_a_1");

    bus(1'b1, 1'b0, 2'd1, 32'h2, 1'b0, 32'h0, "mask2");
    @(negedge clk);
    in_b = 4'hD;
    repeat (3) @(negedge clk);
    in_b = 4'hF;
    cycles(8);
    #1;
    chk("glitch_irq_b", 32'(irq_b), 32'h0);
    bus(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 32'hF, "glitch_data_b");
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b1, 32'h0, "glitch_cap_b");

    @(negedge clk);
    in_b = 4'hD;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1; chk("db_e4_irq_b", 32'(irq_b), 32'h0);
    @(posedge clk);
    #1; chk("db_e5_irq_b", 32'(irq_b), 32'h1);
    bus(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 32'hD, "db_data_b");
    @(negedge clk);
    in_b = 4'hF;
    cycles(8);
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b1, 32'h2, "db_cap_b");

    @(negedge clk);
    in_a = 4'hC;
    cycles(3);
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h3, "w1c_pre");
    bus(1'b1, 1'b0, 2'd2, 32'h1, 1'b0, 32'h0, "w1c_wr1");
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h2, "w1c_post");
    @(negedge clk);
    in_a = 4'hE;
    cycles(3);
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h2, "rise_nocap");
    @(negedge clk);
    in_a = 4'hC;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    bus(1'b1, 1'b0, 2'd2, 32'h2, 1'b0, 32'h0, "w1c_conflict");
    bus(1'b0, 1'b1, 2'd2, 32'h0, 1'b0, 32'h2, "edge_wins");

    chk("irq_a_on", 32'(irq_a), 32'h1);
    bus(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 32'h0, "mask0");
    chk("irq_a_masked", 32'(irq_a), 32'h0);
    bus(1'b1, 1'b0, 2'd1, 32'h2, 1'b0, 32'h0, "mask2b");
    chk("irq_a_again", 32'(irq_a), 32'h1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_irq_a", 32'(irq_a), 32'h0);
    chk("async_out_a", 32'(out_a), 32'h0);
    chk("async_out_b", 32'(out_b), 32'h0);
    chk("async_rd_a", rdata_a, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pio_edge_capture_slave.md
Name: pio_edge_capture_slave

Overview:
Avalon-MM responder PIO for the FPGA fabric, serving requests from the HPS lightweight bridge. It samples external inputs such as buttons and DIP switches through a synchroniser and per-bit debouncer, then latches edges into a write-1-to-clear capture register. It raises a level interrupt through a mask and drives an output register such as the LEDs. This is the target end of the bus transactions the HPS issues to the PIO peripherals.

Parameters:
- IN_WIDTH, 4: number of input bits (1..32).
- OUT_WIDTH, 7: number of output bits (1..32).
- DEBOUNCE_CYCLES, 4: stable cycles needed to accept an input change. 0 = bypass.
- EDGE_MODE, 1: edge that sets capture. 0 = rising, 1 = falling, 2 = either.

Ports:
- clk_clk, in, 1: sole clock.
- reset_reset_n, in, 1: asynchronous active-low reset.
- avs_address, in, 2: register select.
- avs_read, in, 1: read strobe.
- avs_write, in, 1: write strobe.
- avs_writedata, in, 32: write data.
- avs_readdata, out, 32: read data, fixed latency 1.
- irq, out, 1: level interrupt, active high.
- in_port, in, IN_WIDTH: asynchronous external inputs.
- out_port, out, OUT_WIDTH: output register value.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (reset_reset_n), all flops cleared on assertion; deassertion handled by upstream synchroniser.
- Reset values: avs_readdata=0, irq=0, out_port=0. Internally sync stages s1/s2=0, debounced d=0, counters=0, irq_mask=0, capture=0.
- Synchroniser: s1<=in_port, s2<=s1 every cycle.
- Debounce, DEBOUNCE_CYCLES=0: d<=s2 every cycle.
- Debounce, DEBOUNCE_CYCLES=N>0: per bit, counter width clog2(N+1).
  - s2==d: counter<=0.
  - s2!=d and counter<N-1: counter++.
  - s2!=d and counter==N-1: d<=s2, counter<=0.
  - Net effect: a change must persist N consecutive cycles at s2. Shorter glitches are rejected and the counter restarts on any return to d.
- Edge capture: a bit sets in the same cycle its d updates with the selected edge polarity (rising 0->1, falling 1->0, or either).
- Latency, bypass mode: in_port changes before edge k, then s1@k, s2@k+1, d and capture@k+2. With N>0, d updates at k+1+N.
- Register map (word addresses; unused/upper bits read 0, writes to them ignored):
  - 0 DATA: RO, d. Writes ignored.
  - 1 IRQ_MASK: RW, IN_WIDTH bits.
  - 2 EDGE_CAPTURE: W1C. Writing 1 clears the bit, writing 0 has no effect.
  - 3 OUTPUT: RW, OUT_WIDTH bits. out_port = this register directly.
- Write/new-edge conflict: on the same cycle, the new edge wins and the bit stays 1.
- Writes take effect at the clock edge where avs_write=1. No waitrequest; every access completes.
- Reads: avs_readdata is registered on the edge where avs_read=1, valid the following cycle. It holds its value until the next read.
- Read and write in the same cycle: the read returns the pre-write value.
- avs_read and avs_write both low: no state change except input path.
- irq = OR(capture & irq_mask). Pure OR-reduce of flops, no extra pipeline. Drops the cycle after the clearing write or mask write.
- Reset mid-operation: all state clears immediately and asynchronously. irq and out_port go to 0 with no clock needed.
- Counters never overflow. Max value N-1.

Test Plan:
- Reset: hold reset_reset_n=0 with in_port=4'hF and clock running -> out_port=0, irq=0, avs_readdata=0. After release, bypass build, reading DATA after 4 cycles returns 0x0000000F.
- Bypass latency (DEBOUNCE_CYCLES=0, EDGE_MODE=1): in_port 4'hF->4'hE before edge k -> capture bit0=1 at k+2. With IRQ_MASK=1, irq=1 at k+2. Reading addr2 returns 0x1.
- Glitch rejection (N=4): bit1 low for 3 cycles then high -> DATA unchanged, capture=0. Low held 6 cycles -> d bit1 falls exactly 4 cycles after s2 falls, capture bit1=1.
- W1C plus simultaneous edge: capture=0x3, write addr2=0x1 -> capture=0x2. Write 0x2 in the same cycle a new falling edge on bit1 occurs -> capture bit1 stays 1.
- Output/mask: write addr3=0xFFFFFFFF -> out_port=7'h7F, read addr3=0x0000007F. Write addr1=0 with capture nonzero -> irq=0 next cycle.
- Read/write same cycle: write addr3=0x15 while reading addr3 (old 0x7F) -> readdata=0x7F. Next read returns 0x15.
